dma_sequencer: RTL and testbench

//   Host-side initiator for the am2940 DMA address generator. Takes one transfer request
//   (mode, start address, word count) and programs the am2940 over instr/datain. It then

---
 rtl/dma_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_dma_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_sequencer.sv
// dma_sequencer: programs an am2940 DMA address generator, then runs
// req/ack memory beats, stepping the am2940 counters via cina/cinw.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, cfg_*        one-cycle transfer request with mode/addr/count
//   abort               host abort, any non-idle state
//   instr, datain       am2940 instruction and data
//   cina, cinw          am2940 carry-ins (active low = count)
//   dataout, oedata     am2940 read-back data and valid
//   am_done, address    am2940 done flag and address counter
//   mem_req, mem_addr   memory beat request and address
//   mem_ack             memory beat accepted
//   busy, done_pulse    status
//   err, residual       abort/timeout flag, captured word count
//   beats               acked beats in the current/last transfer
module dma_sequencer #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] cfg_mode,
  input  logic [7:0] cfg_addr,
  input  logic [7:0] cfg_count,
  input  logic       abort,
  output logic [2:0] instr,
  output logic [7:0] datain,
  output logic       cina,
  output logic       cinw,
  input  logic [7:0] dataout,
  input  logic       oedata,
  input  logic       am_done,
  input  logic [7:0] address,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  output logic       busy,
  output logic       done_pulse,
  output logic       err,
  output logic [7:0] residual,
  output logic [8:0] beats
);

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(ACK_TIMEOUT);

  localparam logic [2:0] I_WRCR = 3'd0;
  localparam logic [2:0] I_RDWC = 3'd2;
  localparam logic [2:0] I_RDAC = 3'd3;
  localparam logic [2:0] I_LDAD = 3'd5;
  localparam logic [2:0] I_LDWC = 3'd6;
  localparam logic [2:0] I_ENCT = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRCR,
    S_LDAD,
    S_LDWC,
    S_XFER,
    S_RDWC,
    S_FIN
  } state_t;

  state_t state, state_n;

  logic [2:0]    mode_q;
  logic [7:0]    addr_q;
  logic [7:0]    count_q;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_inc;
  logic          zpulse;
  logic          beat;
  logic          stall;
  logic          tmo;
  logic          accept;
  logic          active_abort;

  assign tcnt_inc     = tcnt + 1'b1;
  assign beat         = mem_req & mem_ack;
  assign stall        = mem_req & ~mem_ack;
  assign accept       = (state == S_IDLE) & start;
  assign active_abort = (state != S_IDLE) & abort;

  assign mem_addr   = address;
  assign busy       = (state != S_IDLE);
  // Zero-count requests never leave IDLE, so their strobe is registered.
  assign done_pulse = (state == S_FIN) | zpulse;

  always_comb begin
    state_n = state;
    instr   = I_RDAC;
    datain  = '0;
    mem_req = 1'b0;
    cina    = 1'b1;
    cinw    = 1'b1;
    tmo     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && cfg_count != 8'd0)
          state_n = S_WRCR;
      end
      S_WRCR: begin
        instr   = I_WRCR;
        datain  = {5'b0, mode_q};
        state_n = S_LDAD;
      end
      S_LDAD: begin
        instr   = I_LDAD;
        datain  = addr_q;
        state_n = S_LDWC;
      end
      S_LDWC: begin
        instr   = I_LDWC;
        datain  = count_q;
        state_n = S_XFER;
      end
      S_XFER: begin
        instr   = I_ENCT;
        // Abort withdraws the request so a same-cycle ack is void.
        mem_req = ~am_done & ~abort;
        cina    = ~(mem_req & mem_ack);
        cinw    = ~(mem_req & mem_ack);
        tmo     = stall & (tcnt_inc == TO_MAX);
        if (am_done || tmo)
          state_n = S_RDWC;
      end
      S_RDWC: begin
        instr = I_RDWC;
        if (oedata)
          state_n = S_FIN;
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    if (active_abort)
      state_n = S_RDWC;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      mode_q   <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      tcnt     <= '0;
      zpulse   <= 1'b0;
      err      <= 1'b0;
      residual <= '0;
      beats    <= '0;
    end else begin
      state  <= state_n;
      zpulse <= 1'b0;
      if (accept) begin
        err   <= 1'b0;
        beats <= '0;
        tcnt  <= '0;
        if (cfg_count == 8'd0) begin
          err    <= 1'b1;
          zpulse <= 1'b1;
        end else begin
          mode_q  <= cfg_mode;
          addr_q  <= cfg_addr;
          count_q <= cfg_count;
        end
      end
      if (state == S_XFER) begin
        if (beat) begin
          tcnt <= '0;
          if (beats != 9'h1FF)
            beats <= beats + 9'd1;
        end else if (stall) begin
          tcnt <= tcnt_inc;
        end
        if (tmo)
          err <= 1'b1;
      end
      if (state == S_RDWC && oedata && !abort)
        residual <= dataout;
      if (active_abort)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_sequencer.sv
// tb_dma_sequencer: directed scoreboard bench for dma_sequencer with a
// behavioural am2940 and a policy-driven memory acknowledger.
module tb_dma_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] cfg_mode = '0;
  logic [7:0] cfg_addr = '0;
  logic [7:0] cfg_count = '0;
  logic       abort = 1'b0;
  logic [2:0] instr;
  logic [7:0] datain;
  logic       cina, cinw;
  logic [7:0] dataout;
  logic       oedata;
  logic       am_done;
  logic [7:0] address;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic       busy, done_pulse, err;
  logic [7:0] residual;
  logic [8:0] beats;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  dma_sequencer #(.ACK_TIMEOUT(5)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_mode(cfg_mode), .cfg_addr(cfg_addr), .cfg_count(cfg_count),
    .abort(abort), .instr(instr), .datain(datain),
    .cina(cina), .cinw(cinw), .dataout(dataout), .oedata(oedata),
    .am_done(am_done), .address(address), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .busy(busy),
    .done_pulse(done_pulse), .err(err), .residual(residual),
    .beats(beats)
  );

  // am2940 model: control register, address counter, word counter.
  logic [2:0] am_cr = '0;
  logic [7:0] am_ac = '0;
  logic [7:0] am_wc = 8'd1;

  assign address = am_ac;
  assign am_done = (am_wc == 8'd0);
  assign dataout = am_wc;
  assign oedata  = (instr == 3'd2);

  always @(posedge clk) begin
    case (instr)
      3'd0: am_cr <= datain[2:0];
      3'd5: am_ac <= datain;
      3'd6: am_wc <= datain;
      3'd7: begin
        if (!cina) am_ac <= am_cr[2] ? am_ac - 8'd1 : am_ac + 8'd1;
        if (!cinw) am_wc <= am_wc - 8'd1;
      end
      default: ;
    endcase
  end

  // Ack policy: 0 always, 1 after two stalled cycles, 2 never.
  int pol = 0;
  int dly = 0;
  always @(negedge clk) begin
    if (pol == 0) begin
      mem_ack = 1'b1;
    end else if (pol == 1) begin
      if (mem_req) begin
        if (dly == 2) begin
          mem_ack = 1'b1;
          dly = 0;
        end else begin
          mem_ack = 1'b0;
          dly = dly + 1;
        end
      end else begin
        mem_ack = 1'b0;
      end
    end else begin
      mem_ack = 1'b0;
    end
  end

  typedef struct {
    logic       e_err;
    logic [7:0] e_res;
    logic [8:0] e_beats;
    int         e_reqc;
  } done_t;

  logic [7:0] aq[$];
  done_t      dq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: checks beats, carry-ins and completions away from the edge.
  int reqc = 0;
  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      reqc = 0;
    end else begin
      if (mem_req) reqc++;
      chk("cina", {31'b0, cina},
          {31'b0, !(instr == 3'd7 && mem_req && mem_ack)});
      chk("cinw", {31'b0, cinw},
          {31'b0, !(instr == 3'd7 && mem_req && mem_ack)});
      if (mem_req && mem_ack) begin
        if (aq.size() == 0) begin
          chk("extra_beat", {24'b0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] ea;
          ea = aq.pop_front();
          chk("mem_addr", {24'b0, mem_addr}, {24'b0, ea});
        end
      end
      if (done_pulse) begin
        if (dq.size() == 0) begin
          chk("extra_done", 32'd1, 32'd0);
        end else begin
          done_t d;
          d = dq.pop_front();
          chk("err", {31'b0, err}, {31'b0, d.e_err});
          chk("residual", {24'b0, residual}, {24'b0, d.e_res});
          chk("beats", {23'b0, beats}, {23'b0, d.e_beats});
          chk("req_cycles", reqc, d.e_reqc);
        end
        reqc = 0;
      end
    end
  end

  task automatic launch(input logic [2:0] m, input logic [7:0] a,
                        input logic [7:0] c, input int p,
                        input logic [7:0] ea[$], input done_t d);
    foreach (ea[i]) aq.push_back(ea[i]);
    dq.push_back(d);
    @(negedge clk);
    pol = p;
    dly = 0;
    cfg_mode = m;
    cfg_addr = a;
    cfg_count = c;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n;
    n = 0;
    while (dq.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({nm, "_timeout"}, dq.size(), 0);
    repeat (2) @(posedge clk);
    chk({nm, "_missing_beats"}, aq.size(), 0);
    #1 chk({nm, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_instr"}, {29'b0, instr}, 32'd3);
    chk({nm, "_datain"}, {24'b0, datain}, 32'd0);
    chk({nm, "_cina"}, {31'b0, cina}, 32'd1);
    chk({nm, "_cinw"}, {31'b0, cinw}, 32'd1);
    chk({nm, "_mem_req"}, {31'b0, mem_req}, 32'd0);
    chk({nm, "_busy"}, {31'b0, busy}, 32'd0);
    chk({nm, "_done"}, {31'b0, done_pulse}, 32'd0);
    chk({nm, "_err"}, {31'b0, err}, 32'd0);
    chk({nm, "_residual"}, {24'b0, residual}, 32'd0);
    chk({nm, "_beats"}, {23'b0, beats}, 32'd0);
  endtask

  initial begin
    logic [7:0] ea[$];
    done_t d;

    repeat (2) @(posedge clk);
    #1 chk_reset_vals("rst");
    @(negedge clk);
    reset = 1'b0;

    // 1: increment, ack every cycle; first request four cycles after start.
    ea = '{8'h10, 8'h11, 8'h12, 8'h13};
    d = '{1'b0, 8'h00, 9'd4, 4};
    launch(3'b000, 8'h10, 8'd4, 0, ea, d);
    chk("t1_wrcr_instr", {29'b0, instr}, 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("t1_ldwc_data", {24'b0, datain}, 32'h04);
    chk("t1_no_req_yet", {31'b0, mem_req}, 32'd0);
    @(posedge clk);
    #1 chk("t1_first_req", {31'b0, mem_req}, 32'd1);
    wait_done("t1", 100);

    // 2: decrement across the 00 -> FF wrap.
    ea = '{8'h01, 8'h00, 8'hFF};
    d = '{1'b0, 8'h00, 9'd3, 3};
    launch(3'b100, 8'h01, 8'd3, 0, ea, d);
    wait_done("t2", 100);

    // 3: two idle ack cycles before every beat.
    ea = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
    d = '{1'b0, 8'h00, 9'd8, 24};
    launch(3'b000, 8'h40, 8'd8, 1, ea, d);
    wait_done("t3", 200);

    // 4: abort after two beats, with ack high in the abort cycle.
    ea = '{8'h80, 8'h81};
    d = '{1'b1, 8'd4, 9'd2, 2};
    launch(3'b000, 8'h80, 8'd6, 0, ea, d);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_done("t4", 100);

    // 5: no acks at all, timeout after five request cycles.
    ea = {};
    d = '{1'b1, 8'd3, 9'd0, 5};
    launch(3'b000, 8'h20, 8'd3, 2, ea, d);
    wait_done("t5", 100);

    // 6: zero count stays idle and strobes done with err.
    d = '{1'b1, 8'd3, 9'd0, 0};
    launch(3'b000, 8'h30, 8'd0, 0, ea, d);
    chk("t6_instr", {29'b0, instr}, 32'd3);
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_done", {31'b0, done_pulse}, 32'd1);
    chk("t6_err", {31'b0, err}, 32'd1);
    wait_done("t6", 20);

    // Reset in the middle of a stalled transfer.
    dq.push_back('{1'b0, 8'h00, 9'd0, 0});
    @(negedge clk);
    pol = 2;
    cfg_count = 8'd4;
    cfg_addr = 8'h50;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("rx_in_xfer", {29'b0, instr}, 32'd7);
    reset = 1'b1;
    void'(dq.pop_front());
    @(posedge clk);
    #1 chk_reset_vals("rx");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("rx_stays_idle", {31'b0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
